// File: rtl/adc_sample_fifo_if.sv
// rtl/adc_sample_fifo_if.sv - stream and status bundle for the ADC sample FIFO
//
// Purpose: groups the sample input, the ready/valid output stream and the
//          overflow/status signals of adc_sample_fifo.
// Signals:
//   in_data/in_valid      ADC sample strobe (no backpressure)
//   out_data/out_valid/out_ready  head-of-queue ready/valid stream
//   level, almost_full    occupancy status
//   overflow, drop_count  sticky drop flag and saturating drop counter
//   clear_overflow        synchronous clear of overflow and drop_count
// Modports: slave = the FIFO, master = the producer/consumer side.
interface adc_sample_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LW-1:0]         level;
  logic                  almost_full;
  logic                  overflow;
  logic [15:0]           drop_count;
  logic                  clear_overflow;

  modport slave (
    input  in_data, in_valid, out_ready, clear_overflow,
    output out_data, out_valid, level, almost_full, overflow, drop_count
  );

  modport master (
    output in_data, in_valid, out_ready, clear_overflow,
    input  out_data, out_valid, level, almost_full, overflow, drop_count
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - register FIFO buffering ADC decimator samples
//
// Purpose: stores single-cycle ADC sample strobes in a DEPTH-entry register
//          array and presents them on a ready/valid stream. Samples arriving
//          while full (with no pop on the same edge) are dropped, which sets
//          a sticky overflow flag and bumps a saturating 16-bit drop counter.
// Ports:
//   clk  sole clock
//   rst  asynchronous, active-high reset
//   bus  adc_sample_fifo_if.slave (sample input, output stream, status)
module adc_sample_fifo #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_sample_fifo_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic [15:0]           drop_q;

  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full = (level_q == FULL_LEVEL);
    pop  = (level_q != '0) && bus.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push = bus.in_valid && (!full || pop);
    drop = bus.in_valid && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // A drop coinciding with a clear wins: the counter restarts at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (bus.clear_overflow) begin
        drop_q <= 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end else if (bus.clear_overflow) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  // All status outputs come from registers only.
  assign bus.out_data    = mem[rd_ptr];
  assign bus.out_valid   = (level_q != '0);
  assign bus.level       = level_q;
  assign bus.almost_full = (level_q >= AF_LEVEL);
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb/tb_adc_sample_fifo.sv - self-checking bench for adc_sample_fifo
module tb_adc_sample_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_sample_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a queue of stored samples plus overflow bookkeeping.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            m_dc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
  endtask

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bit dropped = 1'b0;
    if (mq.size() > 0 && r) void'(mq.pop_front());
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_dc  = c ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
  endtask

  task automatic compare_all();
    chk("level", bus.level, mq.size());
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("almost_full", bus.almost_full, mq.size() >= AFL);
    chk("overflow", bus.overflow, m_ovf);
    chk("drop_count", bus.drop_count, m_dc);
    if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bus.in_valid       = v;
    bus.in_data        = d;
    bus.out_ready      = r;
    bus.clear_overflow = c;
    @(posedge clk);
    #1;
    model_edge(v, d, r, c);
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_almost_full"}, bus.almost_full, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_drop_count"}, bus.drop_count, 0);
  endtask

  initial begin
    logic [DW-1:0] ord [3];
    ord[0] = 16'h0001; ord[1] = 16'h8000; ord[2] = 16'h7FFF;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
    model_reset();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Fill partly with a drop, then assert reset between edges.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 16'h1230 + 16'(i), 1'b0, 1'b0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
    rst = 1'b1;
    #2;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();

    // Ordering: three pushes, then drain with out_ready held high.
    for (int i = 0; i < 3; i++) step(1'b1, ord[i], 1'b0, 1'b0);
    chk("order_level3", bus.level, 3);
    for (int i = 0; i < 3; i++) begin
      chk("order_head", bus.out_data, ord[i]);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("order_level", bus.level, 2 - i);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("order_empty", bus.out_valid, 0);

    // Overflow: 18 pushes into a 16-deep FIFO.
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 10) chk("af_before_12th", bus.almost_full, 0);
      if (i == 11) chk("af_at_12th", bus.almost_full, 1);
    end
    chk("ovf_level", bus.level, 16);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_drops", bus.drop_count, 2);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_readout", bus.out_data, i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("ovf_drained", bus.out_valid, 0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hABCD, 1'b1, 1'b0);
    chk("full_pp_level", bus.level, 16);
    chk("full_pp_drops", bus.drop_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 15) chk("abcd_16th", bus.out_data, 16'hABCD);
      step(1'b0, '0, 1'b1, 1'b0);
    end

    // Clear colliding with a drop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i * 7), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("clr_dc5", bus.drop_count, 5);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("clr_coll_ovf", bus.overflow, 1);
    chk("clr_coll_dc", bus.drop_count, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_alone_ovf", bus.overflow, 0);
    chk("clr_alone_dc", bus.drop_count, 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap: 40 random samples, out_ready pattern 1-0-1-1.
    for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), (i % 4) != 1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_drops", bus.drop_count, 0);
    chk("wrap_empty", bus.out_valid, 0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
